// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - pipeline/hazard-controller signal bundle
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [3:0]       id_src1;
   logic [3:0]       id_src2;
   logic             id_use_src1;
   logic             id_two_src;
   logic [3:0]       exe_dest;
   logic             exe_WB_EN;
   logic             exe_MEM_R_EN;
   logic [3:0]       mem_dest;
   logic             mem_WB_EN;
   logic             exe_B;
   logic             mem_access;
   logic             sram_ready;
   logic             if_freeze;
   logic             if_flush;
   logic             id_flush;
   logic             exe_freeze;
   logic             mem_freeze;
   logic             mem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] wait_cnt;

   modport master (
      output id_src1, id_src2, id_use_src1, id_two_src, exe_dest, exe_WB_EN,
             exe_MEM_R_EN, mem_dest, mem_WB_EN, exe_B, mem_access, sram_ready,
      input  if_freeze, if_flush, id_flush, exe_freeze, mem_freeze, mem_timeout,
             stall_cnt, flush_cnt, wait_cnt
   );

   modport slave (
      input  id_src1, id_src2, id_use_src1, id_two_src, exe_dest, exe_WB_EN,
             exe_MEM_R_EN, mem_dest, mem_WB_EN, exe_B, mem_access, sram_ready,
      output if_freeze, if_flush, id_flush, exe_freeze, mem_freeze, mem_timeout,
             stall_cnt, flush_cnt, wait_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer with SRAM-wait watchdog and perf counters
// Define PIPE_FORWARDING_EN to stall on load-use only; otherwise full interlock.
module pipeline_hazard_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input logic                   clk,
   input logic                   rst,
   pipeline_hazard_ctrl_if.slave hz_if
);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [TW-1:0]    r_wtimer;
   logic [TW-1:0]    w_wtimer_nxt;
   logic             r_timeout;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic [CNT_W-1:0] r_wait_cnt;

   logic w_hz, w_mw;
   logic w_if_freeze, w_if_flush, w_id_flush, w_exe_freeze, w_mem_freeze;
   logic w_stall_inc, w_flush_inc, w_wait_inc, w_timeout_set;

   function automatic logic src_match(input logic [3:0] dest,
                                      input logic [3:0] s1, input logic u1,
                                      input logic [3:0] s2, input logic u2);
      return (u1 && (s1 == dest)) || (u2 && (s2 == dest));
   endfunction

   always_comb begin
`ifdef PIPE_FORWARDING_EN
      w_hz = hz_if.exe_MEM_R_EN && hz_if.exe_WB_EN &&
             src_match(hz_if.exe_dest, hz_if.id_src1, hz_if.id_use_src1,
                       hz_if.id_src2, hz_if.id_two_src);
`else
      w_hz = (hz_if.exe_WB_EN &&
              src_match(hz_if.exe_dest, hz_if.id_src1, hz_if.id_use_src1,
                        hz_if.id_src2, hz_if.id_two_src)) ||
             (hz_if.mem_WB_EN &&
              src_match(hz_if.mem_dest, hz_if.id_src1, hz_if.id_use_src1,
                        hz_if.id_src2, hz_if.id_two_src));
`endif
   end

   assign w_mw = hz_if.mem_access && !hz_if.sram_ready;

   always_comb begin
      w_next        = r_state;
      w_wtimer_nxt  = r_wtimer;
      w_if_freeze   = 1'b0;
      w_if_flush    = 1'b0;
      w_id_flush    = 1'b0;
      w_exe_freeze  = 1'b0;
      w_mem_freeze  = 1'b0;
      w_stall_inc   = 1'b0;
      w_flush_inc   = 1'b0;
      w_wait_inc    = 1'b0;
      w_timeout_set = 1'b0;
      if (rst) begin
         w_next = RUN;
      end else if (r_state == ERR) begin
         w_if_freeze  = 1'b1;
         w_exe_freeze = 1'b1;
         w_mem_freeze = 1'b1;
      end else if (w_mw) begin
         // Pending branch/hazard stays in the frozen registers and is re-evaluated on release
         w_if_freeze  = 1'b1;
         w_exe_freeze = 1'b1;
         w_mem_freeze = 1'b1;
         w_wait_inc   = 1'b1;
         if (r_state == RUN) begin
            w_next       = WAIT;
            w_wtimer_nxt = TW'(1);
         end else if (r_wtimer == TW'(TIMEOUT)) begin
            w_next        = ERR;
            w_timeout_set = 1'b1;
         end else begin
            w_wtimer_nxt = r_wtimer + TW'(1);
         end
      end else begin
         w_next = RUN;
         if (hz_if.exe_B) begin
            w_if_flush  = 1'b1;
            w_id_flush  = 1'b1;
            w_flush_inc = 1'b1;
         end else if (w_hz) begin
            w_if_freeze = 1'b1;
            w_id_flush  = 1'b1;
            w_stall_inc = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= RUN;
         r_wtimer    <= '0;
         r_timeout   <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
         r_wait_cnt  <= '0;
      end else begin
         r_state  <= w_next;
         r_wtimer <= w_wtimer_nxt;
         if (w_timeout_set)
            r_timeout <= 1'b1;
         if (w_stall_inc && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         if (w_flush_inc && (r_flush_cnt != '1))
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         if (w_wait_inc && (r_wait_cnt != '1))
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
      end
   end

   assign hz_if.if_freeze   = w_if_freeze;
   assign hz_if.if_flush    = w_if_flush;
   assign hz_if.id_flush    = w_id_flush;
   assign hz_if.exe_freeze  = w_exe_freeze;
   assign hz_if.mem_freeze  = w_mem_freeze;
   assign hz_if.mem_timeout = r_timeout;
   assign hz_if.stall_cnt   = r_stall_cnt;
   assign hz_if.flush_cnt   = r_flush_cnt;
   assign hz_if.wait_cnt    = r_wait_cnt;
endmodule
